rf_wb_arb: RTL and testbench
============================

RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock, rising edge active.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) has a write.
REQ-005 req0_wa  input  5  requester 0 destination register.
REQ-006 req0_wd  input  32  requester 0 write data.
REQ-007 req0_ready  output  1  requester 0 may present a write this cycle.
REQ-008 req1_valid, req1_wa, req1_wd, req1_ready  same widths and meanings as requester 0, for requester 1 (load/long-latency writeback).
REQ-009 we  output  1  register-file write enable.
REQ-010 wa  output  5  register-file write address.
REQ-011 wd  output  32  register-file write data.
REQ-012 busy  output  1  any write is pending or being issued.
REQ-013 qa  input  5  hazard query address.
REQ-014 q_hit  output  1  a pending write targets qa.

Function
REQ-015 Each requester SHALL own a 2-entry FIFO; a write is accepted on a rising edge when valid and ready are both high.
REQ-016 readyN SHALL be high exactly when FIFO N holds fewer than 2 entries, computed from the registered count; a same-cycle pop SHALL NOT make a full FIFO ready.
REQ-017 An accepted write with wa == 0 SHALL be consumed and discarded, never enqueued and never driven to the register file.
REQ-018 Each cycle the arbiter SHALL pop at most one FIFO head, choosing among non-empty FIFOs by round-robin with a 1-bit priority pointer (requester 0 first after reset).
REQ-019 After a grant to requester i, the pointer SHALL point to the other requester; with no grant, the pointer SHALL be unchanged.
REQ-020 we, wa, and wd SHALL be registered: a head popped on edge k SHALL drive we=1 with its wa/wd during the cycle after edge k. When no pop occurs, we SHALL be 0 and wa/wd SHALL hold their previous values.
REQ-021 Minimum latency SHALL be 2 cycles: accept on edge k, then pop on edge k+1, then we is high during cycle k+1 to k+2.
REQ-022 Per-requester order SHALL be preserved; writes to the same register from different requesters SHALL issue in grant order.
REQ-023 Simultaneous push and pop on the same FIFO SHALL be supported when the FIFO is not full.
REQ-024 busy SHALL equal (FIFO0 non-empty) OR (FIFO1 non-empty) OR we.
REQ-025 Sustained valid on both requesters SHALL yield exactly one write per cycle, alternating 0,1,0,1.

Reset
REQ-026 While rst is high on an edge, both FIFOs SHALL be emptied, the pointer SHALL be set to 0, and we, wa, and wd SHALL be set to 0.
REQ-027 During the cycle after a reset edge, req0_ready and req1_ready SHALL be 1, and busy and q_hit SHALL be 0.
REQ-028 A reset asserted mid-operation SHALL drop all pending writes without issuing them.

Configuration
REQ-029 Macro RF_WB_ARB_HAZARD_EN: when defined, q_hit SHALL be combinational and high when qa != 0 and qa matches any valid FIFO entry or the wa of the output register while we=1.
REQ-030 When RF_WB_ARB_HAZARD_EN is not defined, qa SHALL be ignored, q_hit SHALL be tied to 0, and the port list SHALL be unchanged.

Structure
REQ-031 Package rf_wb_pkg SHALL hold REG_AW=5, DATA_W=32, WB_FIFO_DEPTH=2, and typedef wb_entry_t {wa, wd}.
REQ-032 Sub-module wb_fifo (2-entry, push/pop, count, entry visibility for hazard match) SHALL be instantiated once per requester.

Verification
REQ-033 Single write: req0 writes x5=0x1234 on edge 1 -> we=1, wa=5, wd=0x1234 during cycle 2-3 only.
REQ-034 Contention: both requesters valid on one edge (x1=0xA, x2=0xB) -> x1 issues first, x2 on the next cycle, and the pointer returns to 0.
REQ-035 Backpressure: req1 pushes 3 writes on consecutive edges while req0 holds priority -> req1_ready=0 after the 2nd push, and the 3rd write is accepted only after a pop.
REQ-036 x0 discard: req0 writes x0=0xFFFFFFFF -> we stays 0 and busy stays 0.
REQ-037 Hazard (macro defined): x7 queued, qa=7 -> q_hit=1; qa=0 -> q_hit=0; after x7 issues, q_hit=0.
REQ-038 Reset mid-operation: both FIFOs full, rst pulsed for one edge -> no we afterward, both readys=1, busy=0.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared widths and the write-back entry type for the register-file write-back arbiter.
package rf_wb_pkg;
  localparam int REG_AW        = 5;
  localparam int DATA_W        = 32;
  localparam int WB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Two-entry write-back FIFO with a fixed head slot, registered count and an
// address-match output that covers every occupied entry.
module wb_fifo
  import rf_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_entry_t         push_data,
  input  logic              pop,
  input  logic [REG_AW-1:0] qa,
  output wb_entry_t         head,
  output logic [1:0]        count,
  output logic              hit
);
  wb_entry_t  slot0_q, slot0_d;
  wb_entry_t  slot1_q, slot1_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (push && pop) begin
      // Head leaves while the new entry lands behind whatever remains.
      if (count_q == 2'd2) begin
        slot0_d = slot1_q;
        slot1_d = push_data;
      end else begin
        slot0_d = push_data;
      end
    end else if (pop) begin
      slot0_d = slot1_q;
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) slot0_d = push_data;
      else                 slot1_d = push_data;
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 2'd0;
    else     count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign head  = slot0_q;
  assign count = count_q;
  assign hit   = ((count_q != 2'd0) && (slot0_q.wa == qa)) ||
                 ((count_q == 2'd2) && (slot1_q.wa == qa));
endmodule

// File: rtl/rf_wb_arb.sv
// Two-requester register-file write-back arbiter: per-requester FIFOs, round-robin
// pop, registered write port. Optional hazard query enabled by RF_WB_ARB_HAZARD_EN.
module rf_wb_arb
  import rf_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [REG_AW-1:0] req0_wa,
  input  logic [DATA_W-1:0] req0_wd,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [REG_AW-1:0] req1_wa,
  input  logic [DATA_W-1:0] req1_wd,
  output logic              req1_ready,
  output logic              we,
  output logic [REG_AW-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              busy,
  input  logic [REG_AW-1:0] qa,
  output logic              q_hit
);
  wb_entry_t         head0, head1, sel;
  logic [1:0]        count0, count1;
  logic              hit0, hit1;
  logic              push0, push1, pop0, pop1;
  logic              ne0, ne1;
  logic              ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  assign req0_ready = (count0 < 2'(WB_FIFO_DEPTH));
  assign req1_ready = (count1 < 2'(WB_FIFO_DEPTH));
  // Writes to x0 are swallowed at the door so they never occupy a slot.
  assign push0 = req0_valid && req0_ready && (req0_wa != '0);
  assign push1 = req1_valid && req1_ready && (req1_wa != '0);
  assign ne0   = (count0 != 2'd0);
  assign ne1   = (count1 != 2'd0);

  wb_fifo u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data ('{wa: req0_wa, wd: req0_wd}),
    .pop       (pop0),
    .qa        (qa),
    .head      (head0),
    .count     (count0),
    .hit       (hit0)
  );

  wb_fifo u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data ('{wa: req1_wa, wd: req1_wd}),
    .pop       (pop1),
    .qa        (qa),
    .head      (head1),
    .count     (count1),
    .hit       (hit1)
  );

  always_comb begin
    pop0  = 1'b0;
    pop1  = 1'b0;
    ptr_d = ptr_q;
    if (ne0 && (!ne1 || !ptr_q)) begin
      pop0  = 1'b1;
      ptr_d = 1'b1;
    end else if (ne1) begin
      pop1  = 1'b1;
      ptr_d = 1'b0;
    end
  end

  always_comb begin
    sel  = pop1 ? head1 : head0;
    we_d = pop0 || pop1;
    wa_d = we_d ? sel.wa : wa_q;
    wd_d = we_d ? sel.wd : wd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= we_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
    end
  end

  assign we   = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;
  assign busy = ne0 || ne1 || we_q;

`ifdef RF_WB_ARB_HAZARD_EN
  assign q_hit = (qa != '0) && (hit0 || hit1 || (we_q && (wa_q == qa)));
`else
  logic unused_hazard;
  assign unused_hazard = hit0 ^ hit1;
  assign q_hit = 1'b0;
`endif
endmodule

// File: tb/tb_rf_wb_arb.sv
// Randomized and directed bench for rf_wb_arb against a queue-based reference model.
module tb_rf_wb_arb;
  import rf_wb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [REG_AW-1:0] req0_wa, req1_wa, qa;
  logic [DATA_W-1:0] req0_wd, req1_wd;
  logic              req0_ready, req1_ready;
  logic              we, busy, q_hit;
  logic [REG_AW-1:0] wa;
  logic [DATA_W-1:0] wd;

  int checks = 0;
  int errors = 0;

  wb_entry_t         m_q0[$];
  wb_entry_t         m_q1[$];
  bit                m_ptr;
  bit                m_we;
  logic [REG_AW-1:0] m_wa;
  logic [DATA_W-1:0] m_wd;

  always #5 clk = ~clk;

  rf_wb_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_wa    (req0_wa),
    .req0_wd    (req0_wd),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_wa    (req1_wa),
    .req1_wd    (req1_wd),
    .req1_ready (req1_ready),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .busy       (busy),
    .qa         (qa),
    .q_hit      (q_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [REG_AW-1:0] q);
    bit h = 1'b0;
`ifdef RF_WB_ARB_HAZARD_EN
    if (q != '0) begin
      foreach (m_q0[i]) if (m_q0[i].wa == q) h = 1'b1;
      foreach (m_q1[i]) if (m_q1[i].wa == q) h = 1'b1;
      if (m_we && m_wa == q) h = 1'b1;
    end
`endif
    return h;
  endfunction

  task automatic step(input bit r,
                      input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] q);
    bit acc0, acc1;
    rst = r; qa = q;
    req0_valid = v0; req0_wa = a0; req0_wd = d0;
    req1_valid = v1; req1_wa = a1; req1_wd = d1;
    @(posedge clk);
    if (r) begin
      m_q0.delete(); m_q1.delete();
      m_ptr = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      acc0 = v0 && (m_q0.size() < 2);
      acc1 = v1 && (m_q1.size() < 2);
      if (m_q0.size() > 0 && (m_q1.size() == 0 || m_ptr == 1'b0)) begin
        wb_entry_t e = m_q0.pop_front();
        m_we = 1'b1; m_wa = e.wa; m_wd = e.wd; m_ptr = 1'b1;
      end else if (m_q1.size() > 0) begin
        wb_entry_t e = m_q1.pop_front();
        m_we = 1'b1; m_wa = e.wa; m_wd = e.wd; m_ptr = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (acc0 && a0 != 0) m_q0.push_back('{wa: a0, wd: d0});
      if (acc1 && a1 != 0) m_q1.push_back('{wa: a1, wd: d1});
    end
    #1;
    chk("we", we, m_we);
    chk("wa", wa, m_wa);
    chk("wd", wd, m_wd);
    chk("req0_ready", req0_ready, m_q0.size() < 2);
    chk("req1_ready", req1_ready, m_q1.size() < 2);
    chk("busy", busy, (m_q0.size() > 0) || (m_q1.size() > 0) || m_we);
    chk("q_hit", q_hit, model_hit(q));
  endtask

  task automatic idle(input int n, input logic [4:0] q);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, q);
  endtask

  initial begin
    m_ptr = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0);

    step(0, 1, 5, 32'h1234, 0, 0, 0, 0);
    idle(4, 0);

    step(0, 1, 1, 32'hA, 1, 2, 32'hB, 0);
    idle(3, 0);
    step(0, 1, 3, 32'h33, 1, 4, 32'h44, 0);
    idle(3, 0);

    step(0, 1, 9, 32'h90, 1, 10, 32'h100, 0);
    step(0, 1, 11, 32'h91, 1, 12, 32'h101, 0);
    step(0, 0, 0, 0, 1, 13, 32'h102, 0);
    step(0, 0, 0, 0, 1, 13, 32'h102, 0);
    step(0, 0, 0, 0, 1, 13, 32'h102, 0);
    idle(5, 0);

    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    idle(3, 0);

    step(0, 0, 0, 0, 1, 7, 32'h77, 7);
    step(0, 0, 0, 0, 0, 0, 0, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 7);

    for (int i = 0; i < 4; i++) step(0, 1, 5'(20 + i), 32'(i), 1, 5'(24 + i), 32'(i + 16), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(4, 0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 40; i++) step(0, 1, 5'($urandom_range(1, 31)), $urandom,
                                      1, 5'($urandom_range(1, 31)), $urandom, 0);
    idle(4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
